// File: rtl/reg_timeout_guard_pkg.sv
// Shared reg-bus types and timeout-guard constants for core_v_mcu.
// Holds the reg_req_t/reg_rsp_t structs and the guard FSM state encoding.
package core_v_mcu_pkg;

   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } reg_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } reg_rsp_t;

   localparam int unsigned RegTimeoutCycles  = 256;
   localparam logic [31:0] RegTimeoutErrData = 32'hBADCAB1E;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } reg_guard_state_e;

endpackage

// File: rtl/reg_timeout_guard.sv
// Zero-latency reg-bus guard: error-completes a request the slave leaves hanging,
// then drains it at the slave. Optional sticky irq under REG_TIMEOUT_GUARD_IRQ_EN.
module reg_timeout_guard
   import core_v_mcu_pkg::*;
#(
   parameter int unsigned TimeoutCycles = RegTimeoutCycles,
   parameter int unsigned CntWidth      = 16,
   parameter logic [31:0] ErrData       = RegTimeoutErrData
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  reg_req_t            mst_req_i,
   output reg_rsp_t            mst_rsp_o,
   output reg_req_t            slv_req_o,
   input  reg_rsp_t            slv_rsp_i,
   output logic                timeout_o,
   output logic                draining_o,
   output logic [CntWidth-1:0] timeout_cnt_o,
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
   output logic                irq_o,
   input  logic                irq_clr_i,
`endif
   output reg_guard_state_e    state_o
);

   localparam int unsigned WaitW = $clog2(TimeoutCycles + 1);
   localparam logic [WaitW-1:0] WaitLast = WaitW'(TimeoutCycles - 1);

   reg_guard_state_e    r_state;
   logic [WaitW-1:0]    r_wait;
   reg_req_t            r_hold;
   logic [CntWidth-1:0] r_cnt;

   logic w_waiting;
   logic w_timeout;

   // Only IDLE waits count; a stalled request during DRAIN never ages.
   assign w_waiting = (r_state == IDLE) && mst_req_i.valid && !slv_rsp_i.ready;
   assign w_timeout = w_waiting && (r_wait == WaitLast);

   always_comb begin
      slv_req_o = mst_req_i;
      mst_rsp_o = slv_rsp_i;
      if (r_state == DRAIN) begin
         slv_req_o       = r_hold;
         slv_req_o.valid = 1'b1;
         mst_rsp_o       = '0;
      end else if (w_timeout) begin
         mst_rsp_o.ready = 1'b1;
         mst_rsp_o.error = 1'b1;
         mst_rsp_o.rdata = ErrData;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_wait  <= '0;
         r_hold  <= '0;
         r_cnt   <= '0;
      end else begin
         r_wait <= (w_waiting && !w_timeout) ? r_wait + 1'b1 : '0;
         case (r_state)
            IDLE: begin
               if (w_timeout) begin
                  r_state <= DRAIN;
                  r_hold  <= mst_req_i;
               end
            end
            DRAIN: begin
               // Late slave answer is dropped; upstream already got the error.
               if (slv_rsp_i.ready) begin
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
         if (w_timeout && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef REG_TIMEOUT_GUARD_IRQ_EN
   logic r_irq;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_irq <= 1'b0;
      end else if (w_timeout) begin
         r_irq <= 1'b1;
      end else if (irq_clr_i) begin
         r_irq <= 1'b0;
      end
   end

   assign irq_o = r_irq;
`endif

   assign timeout_o     = w_timeout;
   assign draining_o    = (r_state == DRAIN);
   assign timeout_cnt_o = r_cnt;
   assign state_o       = r_state;

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Directed bench for reg_timeout_guard with TimeoutCycles=8 and CntWidth=2.
// Covers pass-through, timeout/drain, simultaneous ready, reset in DRAIN, saturation.
module tb_reg_timeout_guard;
   import core_v_mcu_pkg::*;

   localparam int unsigned Tmo = 8;
   localparam int unsigned Cw  = 2;

   logic             clk;
   logic             rst;
   reg_req_t         mst_req;
   reg_rsp_t         mst_rsp;
   reg_req_t         slv_req;
   reg_rsp_t         slv_rsp;
   logic             timeout;
   logic             draining;
   logic [Cw-1:0]    tcnt;
   reg_guard_state_e state;
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
   logic             irq;
   logic             irq_clr;
`endif

   int n_total = 0;
   int n_pass  = 0;

   reg_timeout_guard #(
      .TimeoutCycles(Tmo),
      .CntWidth     (Cw),
      .ErrData      (32'hBADCAB1E)
   ) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .mst_req_i    (mst_req),
      .mst_rsp_o    (mst_rsp),
      .slv_req_o    (slv_req),
      .slv_rsp_i    (slv_rsp),
      .timeout_o    (timeout),
      .draining_o   (draining),
      .timeout_cnt_o(tcnt),
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
      .irq_o        (irq),
      .irq_clr_i    (irq_clr),
`endif
      .state_o      (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   initial begin
      rst     = 1'b1;
      mst_req = '0;
      slv_rsp = '0;
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
      irq_clr = 1'b0;
`endif
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_state", 32'(state), 32'(IDLE));
      chk("rst_slv_valid", 32'(slv_req.valid), 0);
      chk("rst_mst_ready", 32'(mst_rsp.ready), 0);
      chk("rst_mst_error", 32'(mst_rsp.error), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_draining", 32'(draining), 0);
      chk("rst_cnt", 32'(tcnt), 0);
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
      chk("rst_irq", 32'(irq), 0);
`endif

      // Read 0x10, slave ready on the 3rd cycle.
      tick();
      mst_req.addr  = 32'h10;
      mst_req.write = 1'b0;
      mst_req.valid = 1'b1;
      for (int c = 1; c <= 3; c++) begin
         if (c == 3) begin
            slv_rsp.ready = 1'b1;
            slv_rsp.rdata = 32'h1234;
         end
         #1;
         chk("rd_slv_valid", 32'(slv_req.valid), 1);
         chk("rd_slv_addr", slv_req.addr, 32'h10);
         chk("rd_mst_ready", 32'(mst_rsp.ready), (c == 3) ? 1 : 0);
         chk("rd_timeout", 32'(timeout), 0);
         if (c == 3) begin
            chk("rd_rdata", mst_rsp.rdata, 32'h1234);
            chk("rd_error", 32'(mst_rsp.error), 0);
         end
         tick();
      end
      mst_req = '0;
      slv_rsp = '0;

      // Write to 0x40 with a silent slave: times out on the 8th cycle.
      tick();
      mst_req.addr  = 32'h40;
      mst_req.write = 1'b1;
      mst_req.wdata = 32'hCAFE0001;
      mst_req.wstrb = 4'hF;
      mst_req.valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         #1;
         chk("to_pulse", 32'(timeout), (c == 8) ? 1 : 0);
         chk("to_mst_ready", 32'(mst_rsp.ready), (c == 8) ? 1 : 0);
         if (c == 8) begin
            chk("to_error", 32'(mst_rsp.error), 1);
            chk("to_rdata", mst_rsp.rdata, 32'hBADCAB1E);
         end
         tick();
      end
      chk("to_draining", 32'(draining), 1);
      chk("to_cnt", 32'(tcnt), 1);
      chk("to_state", 32'(state), 32'(DRAIN));
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
      chk("to_irq", 32'(irq), 1);
`endif

      // New write to 0x20 stalls while the held request drains.
      mst_req.addr  = 32'h20;
      mst_req.wdata = 32'h55;
      for (int c = 1; c <= 5; c++) begin
         if (c == 5) begin
            slv_rsp.ready = 1'b1;
            slv_rsp.rdata = 32'hDEAD;
         end
         #1;
         chk("dr_slv_addr", slv_req.addr, 32'h40);
         chk("dr_slv_wdata", slv_req.wdata, 32'hCAFE0001);
         chk("dr_slv_valid", 32'(slv_req.valid), 1);
         chk("dr_mst_ready", 32'(mst_rsp.ready), 0);
         chk("dr_timeout", 32'(timeout), 0);
         tick();
      end
      slv_rsp = '0;
      #1;
      chk("post_draining", 32'(draining), 0);
      chk("post_slv_addr", slv_req.addr, 32'h20);
      chk("post_slv_wdata", slv_req.wdata, 32'h55);
      chk("post_mst_ready", 32'(mst_rsp.ready), 0);
      tick();
      slv_rsp.ready = 1'b1;
      #1;
      chk("post_done_ready", 32'(mst_rsp.ready), 1);
      chk("post_done_error", 32'(mst_rsp.error), 0);
      tick();
      mst_req = '0;
      slv_rsp = '0;

      // Slave ready exactly on the threshold cycle: slave wins.
      tick();
      mst_req.addr  = 32'h80;
      mst_req.valid = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         if (c == 8) begin
            slv_rsp.ready = 1'b1;
            slv_rsp.rdata = 32'h77;
         end
         #1;
         chk("sim_timeout", 32'(timeout), 0);
         chk("sim_ready", 32'(mst_rsp.ready), (c == 8) ? 1 : 0);
         if (c == 8) begin
            chk("sim_error", 32'(mst_rsp.error), 0);
            chk("sim_rdata", mst_rsp.rdata, 32'h77);
         end
         tick();
      end
      mst_req = '0;
      slv_rsp = '0;
      #1;
      chk("sim_cnt", 32'(tcnt), 1);
      chk("sim_draining", 32'(draining), 0);

      // Valid dropped early clears the wait count.
      tick();
      mst_req.addr  = 32'h90;
      mst_req.valid = 1'b1;
      for (int c = 1; c <= 5; c++) tick();
      mst_req.valid = 1'b0;
      tick();
      mst_req.valid = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         #1;
         chk("pv_timeout", 32'(timeout), 0);
         tick();
      end
      slv_rsp.ready = 1'b1;
      #1;
      chk("pv_ready", 32'(mst_rsp.ready), 1);
      chk("pv_error", 32'(mst_rsp.error), 0);
      tick();
      mst_req = '0;
      slv_rsp = '0;

      // Timeouts 2..5: counter saturates at 3; clear coinciding with #2 loses.
      for (int k = 2; k <= 5; k++) begin
         tick();
         mst_req.addr  = 32'h100 + 32'(k);
         mst_req.valid = 1'b1;
         for (int c = 1; c <= 8; c++) begin
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
            irq_clr = (c == 8 && k == 2);
`endif
            #1;
            chk("sat_pulse", 32'(timeout), (c == 8) ? 1 : 0);
            tick();
         end
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
         irq_clr = 1'b0;
`endif
         mst_req = '0;
         #1;
         chk("sat_cnt", 32'(tcnt), (k >= 3) ? 3 : k);
         chk("sat_draining", 32'(draining), 1);
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
         chk("sat_irq", 32'(irq), 1);
`endif
         slv_rsp.ready = 1'b1;
         tick();
         slv_rsp = '0;
         #1;
         chk("sat_drained", 32'(draining), 0);
      end
`ifdef REG_TIMEOUT_GUARD_IRQ_EN
      irq_clr = 1'b1;
      tick();
      irq_clr = 1'b0;
      #1;
      chk("irq_cleared", 32'(irq), 0);
`endif

      // Reset while draining.
      tick();
      mst_req.addr  = 32'h200;
      mst_req.valid = 1'b1;
      for (int c = 1; c <= 8; c++) tick();
      mst_req = '0;
      #1;
      chk("rd_pre_draining", 32'(draining), 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("rstd_slv_valid", 32'(slv_req.valid), 0);
      chk("rstd_draining", 32'(draining), 0);
      chk("rstd_cnt", 32'(tcnt), 0);
      chk("rstd_state", 32'(state), 32'(IDLE));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/reg_timeout_guard.md
Name: reg_timeout_guard

Overview:
- Sits between one `reg_req_o`/`reg_rsp_i` port pair of the peripheral reg demux and the register slave behind it.
- Passes transactions through with zero added latency.
- If the slave does not assert ready within `TimeoutCycles`, it completes the transaction upstream with `error=1`, so a hung peripheral cannot lock the reg bus or AXI crossbar.
- It then holds the abandoned request at the slave until the slave finally answers, and counts the event.

Parameters:
- TimeoutCycles, 256, cycles a request may stay valid without ready before error completion; must be >= 2.
- CntWidth, 16, width of the saturating timeout-event counter.
- ErrData, 32'hBADCAB1E, rdata returned upstream on a timeout completion.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- mst_req_i  in  core_v_mcu_pkg::reg_req_t  request from reg demux output.
- mst_rsp_o  out  core_v_mcu_pkg::reg_rsp_t  response to reg demux.
- slv_req_o  out  core_v_mcu_pkg::reg_req_t  request to register slave.
- slv_rsp_i  in  core_v_mcu_pkg::reg_rsp_t  response from register slave.
- timeout_o  out  1  one-cycle pulse on each timeout completion.
- draining_o  out  1  high while an abandoned request is held at the slave.
- timeout_cnt_o  out  CntWidth  saturating count of timeouts.

Behaviour:
- Reg protocol: master holds valid and request fields stable until ready=1. ready may be combinational from valid. One transfer per ready cycle.
- Reset values (outputs after reset):
  - state=IDLE.
  - slv_req_o.valid=0.
  - mst_rsp_o.ready=0, mst_rsp_o.error=0.
  - timeout_o=0, draining_o=0, timeout_cnt_o=0.
  - wait counter=0.
- IDLE (pass-through):
  - slv_req_o=mst_req_i and mst_rsp_o=slv_rsp_i, purely combinational; zero latency.
  - The wait counter (width $clog2(TimeoutCycles+1)) increments each cycle with mst_req_i.valid=1 and slv_rsp_i.ready=0. It clears on ready or when valid=0.
  - Timeout fires when valid=1, ready=0 and wait counter == TimeoutCycles-1, i.e. the TimeoutCycles-th waiting cycle. In that same cycle:
    - mst_rsp_o.ready=1, error=1, rdata=ErrData.
    - timeout_o=1.
    - timeout_cnt_o increments next cycle, saturating at all-ones.
    - The request (addr, write, wdata, wstrb) is latched into a hold register.
    - Next state is DRAIN.
  - Simultaneous case: slave ready in the threshold cycle means the slave response wins; no timeout and no count.
- DRAIN:
  - slv_req_o is driven from the hold register with valid=1.
  - mst_rsp_o.ready=0, so a new upstream request stalls; its wait counter does not run.
  - draining_o=1.
  - When slv_rsp_i.ready=1, the slave response is discarded and the next state is IDLE.
  - There is no timeout on DRAIN itself.
- Protocol violation (upstream drops valid before ready, in IDLE): counter clears, no error, no state change.
- Reset asserted mid-transaction or in DRAIN: next cycle IDLE, hold register cleared, slv_req_o.valid=0, counters 0.

Optional Feature:
- Macro: REG_TIMEOUT_GUARD_IRQ_EN.
- When defined, adds two ports:
  - irq_o  out  1: sticky, set the cycle after timeout_o, and held.
  - irq_clr_i  in  1: clears irq_o next cycle. If set and clear coincide, set wins.
- When undefined: neither port exists and no irq flop is built; all other behaviour is identical.

Decomposition:
- core_v_mcu_pkg gains:
  - RegTimeoutCycles (int unsigned, 256).
  - RegTimeoutErrData (32-bit constant).
  - Typedef reg_guard_state_e {IDLE, DRAIN}.
- reg_req_t and reg_rsp_t are reused from core_v_mcu_pkg.
- No sub-module. The FSM, wait counter, hold register and event counter are all small; one guard is instantiated per NumRegSlaves port at integration.

Test Plan:
- Read at 0x10, slave ready after 3 cycles, rdata=0x1234 -> mst_rsp_o.ready on the 3rd cycle (zero added latency), rdata=0x1234, error=0, timeout_o never high.
- TimeoutCycles=8, slave never ready -> on the 8th valid cycle mst_rsp_o ready=1, error=1, rdata=0xBADCAB1E, timeout_o=1. Next cycle draining_o=1 and timeout_cnt_o=1.
- In DRAIN, a new write to 0x20 is issued; slave ready 5 cycles later -> mst_rsp_o.ready stays 0 throughout. The slave sees the original held addr/wdata. The new write proceeds in IDLE afterwards.
- TimeoutCycles=8, slave ready exactly on the 8th cycle -> normal response, error=0, timeout_o=0, count unchanged.
- rst_i pulsed while draining_o=1 -> next cycle slv_req_o.valid=0, draining_o=0, timeout_cnt_o=0.
- CntWidth=2, 5 timeouts -> timeout_cnt_o reads 1, 2, 3, 3, 3. With REG_TIMEOUT_GUARD_IRQ_EN defined: irq_o=1 after the first; irq_clr_i coinciding with the 2nd timeout pulse leaves irq_o=1.
